// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: controller state encoding, NOP encoding and the
// load-use hazard predicate used by both the controller and the forwarding unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // x0 never carries a real dependency, so rd_ex == 0 can never cause a stall.
    function automatic logic load_use_hazard(
        input logic       is_load_ex,
        input logic       reg_write_ex,
        input logic [4:0] rd_ex,
        input logic [4:0] rs1_id,
        input logic [4:0] rs2_id,
        input logic       uses_rs1_id,
        input logic       uses_rs2_id
    );
        return is_load_ex && reg_write_ex && (rd_ex != 5'd0) &&
               ((uses_rs1_id && (rs1_id == rd_ex)) ||
                (uses_rs2_id && (rs2_id == rd_ex)));
    endfunction

endpackage

// File: rtl/pipe_perf_ctr.sv
// Saturating 32-bit event counter with enable.
module pipe_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall / freeze / bubble / flush sequencing for the 3-stage pipeline with a
// memory-wait watchdog. Performance counters are built only with PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        uses_rs1_id,
    input  logic        uses_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        reg_write_ex,
    input  logic        is_load_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_req_ex,
    input  logic        dmem_ack,
    output logic        stall_if,
    output logic        stall_id,
    output logic        freeze_ex,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic [1:0]  ctrl_state,
    output logic        mem_err,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(MEM_TIMEOUT);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   wait_inc;
    logic             lu, mp, timeout_hit, hold, live;

    assign lu  = load_use_hazard(is_load_ex, reg_write_ex, rd_ex, rs1_id, rs2_id,
                                 uses_rs1_id, uses_rs2_id);
    assign mp  = dmem_req_ex && !dmem_ack;
    assign wait_inc = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // wait_inc includes the current cycle, so ERR follows exactly MEM_TIMEOUT un-acked waits.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_V);

    assign hold = ((state_q == RUN) && mp) || ((state_q == MEM_WAIT) && !dmem_ack) ||
                  (state_q == ERR);
    assign live = (state_q == RUN) || (state_q == MEM_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mp) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (dmem_ack)         state_d = RUN;
                else if (timeout_hit) state_d = ERR;
            end
            ERR:      state_d = ERR;
            default:  state_d = RUN;
        endcase
    end

    // Priority: freeze over flush over load-use stall; everything is quiet under reset.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        freeze_ex = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (!rst) begin
            if (hold) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                freeze_ex = 1'b1;
            end else if (live && branch_taken_ex) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (live && lu) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if ((state_q != MEM_WAIT) && (state_d == MEM_WAIT)) begin
                wait_cnt <= '0;
            end else if ((state_q == MEM_WAIT) && !dmem_ack && (wait_cnt != '1)) begin
                wait_cnt <= wait_inc[CNT_W-1:0];
            end
            if (state_d == ERR) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_ctr u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_if),
        .count (perf_stall_cycles)
    );

    pipe_perf_ctr u_flush_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_id),
        .count (perf_flush_count)
    );
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        uses_rs1_id, uses_rs2_id, reg_write_ex, is_load_ex;
    logic        branch_taken_ex, dmem_req_ex, dmem_ack;
    logic        stall_if, stall_id, freeze_ex, bubble_ex, flush_id, mem_err;
    logic [1:0]  ctrl_state;
    logic [31:0] perf_stall_cycles, perf_flush_count;
    logic [4:0]  ctl;

    int checks = 0;
    int passed = 0;

    // model state: mode 0=RUN 1=MEM_WAIT 2=ERR
    int          m_mode, m_waits;
    logic        m_err;
    logic [31:0] m_stalls, m_flushes;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .rs1_id            (rs1_id),
        .rs2_id            (rs2_id),
        .uses_rs1_id       (uses_rs1_id),
        .uses_rs2_id       (uses_rs2_id),
        .rd_ex             (rd_ex),
        .reg_write_ex      (reg_write_ex),
        .is_load_ex        (is_load_ex),
        .branch_taken_ex   (branch_taken_ex),
        .dmem_req_ex       (dmem_req_ex),
        .dmem_ack          (dmem_ack),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .freeze_ex         (freeze_ex),
        .bubble_ex         (bubble_ex),
        .flush_id          (flush_id),
        .ctrl_state        (ctrl_state),
        .mem_err           (mem_err),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    assign ctl = {stall_if, stall_id, freeze_ex, bubble_ex, flush_id};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = 0; rs2_id = 0; rd_ex = 0;
        uses_rs1_id = 0; uses_rs2_id = 0; reg_write_ex = 0; is_load_ex = 0;
        branch_taken_ex = 0; dmem_req_ex = 0; dmem_ack = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_waits = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Expected {stall_if, stall_id, freeze_ex, bubble_ex, flush_id} for the current inputs.
    function automatic logic [4:0] model_ctl();
        logic lu, mp;
        lu = is_load_ex && reg_write_ex && (rd_ex != 0) &&
             ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex));
        mp = dmem_req_ex && !dmem_ack;
        if (rst) return 5'b00000;
        if (m_mode == 2 || (m_mode == 0 && mp) || (m_mode == 1 && !dmem_ack)) return 5'b11100;
        if (branch_taken_ex) return 5'b00011;
        if (lu) return 5'b11010;
        return 5'b00000;
    endfunction

    task automatic model_advance(input logic [4:0] exp_ctl);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_ctl[4] && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (exp_ctl[0] && m_flushes != 32'hFFFF_FFFF) m_flushes++;
            if (m_mode == 0) begin
                if (dmem_req_ex && !dmem_ack) begin
                    m_mode = 1; m_waits = 0;
                end
            end else if (m_mode == 1) begin
                if (dmem_ack) m_mode = 0;
                else begin
                    m_waits++;
                    if (TO != 0 && m_waits == TO) begin
                        m_mode = 2; m_err = 1;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        is_load_ex = 1; reg_write_ex = 1; rd_ex = 7; rs1_id = 7; uses_rs1_id = 1;
        branch_taken_ex = 1; dmem_req_ex = 1;
        #1;
        checks++;
        if (ctl !== 5'b00000 || ctrl_state !== 2'd0 || mem_err !== 1'b0) begin
            $display("FAIL reset_outputs: ctl=%b state=%0d err=%b, need ctl=00000 state=0 err=0",
                     ctl, ctrl_state, mem_err);
        end else passed++;
        checks++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
            $display("FAIL reset_perf: stall=%0d flush=%0d, need 0/0",
                     perf_stall_cycles, perf_flush_count);
        end else passed++;
        tick();
        idle();
        rst = 0;
        tick();
        model_reset();
    endtask

    task automatic test_load_use();
        idle();
        is_load_ex = 1; reg_write_ex = 1; rd_ex = 5; rs2_id = 5; uses_rs2_id = 1; rs1_id = 3;
        #1;
        checks++;
        if (ctl !== 5'b11010 || ctrl_state !== 2'd0) begin
            $display("FAIL load_use_stall: ctl=%b state=%0d, need ctl=11010 state=0", ctl, ctrl_state);
        end else passed++;
        tick();
        is_load_ex = 0; reg_write_ex = 0; rd_ex = 0;
        #1;
        checks++;
        if (ctl !== 5'b00000 || ctrl_state !== 2'd0) begin
            $display("FAIL load_use_release: ctl=%b state=%0d, need ctl=00000 state=0", ctl, ctrl_state);
        end else passed++;
        tick();
        is_load_ex = 1; reg_write_ex = 1; rd_ex = 0; rs1_id = 0; uses_rs1_id = 1; rs2_id = 0;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            $display("FAIL load_use_x0: ctl=%b, need 00000", ctl);
        end else passed++;
        tick();
        idle();
    endtask

    task automatic test_branch_over_lu();
        idle();
        is_load_ex = 1; reg_write_ex = 1; rd_ex = 9; rs1_id = 9; uses_rs1_id = 1;
        branch_taken_ex = 1;
        #1;
        checks++;
        if (ctl !== 5'b00011) begin
            $display("FAIL branch_over_lu: ctl=%b, need 00011", ctl);
        end else passed++;
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        idle();
        dmem_req_ex = 1;
        #1;
        checks++;
        if (ctl !== 5'b11100 || ctrl_state !== 2'd0) begin
            $display("FAIL mem_first_freeze: ctl=%b state=%0d, need ctl=11100 state=0", ctl, ctrl_state);
        end else passed++;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 5'b11100 || ctrl_state !== 2'd1) begin
                $display("FAIL mem_wait_freeze[%0d]: ctl=%b state=%0d, need ctl=11100 state=1",
                         i, ctl, ctrl_state);
            end else passed++;
            tick();
        end
        dmem_ack = 1; branch_taken_ex = 1;
        #1;
        checks++;
        if (ctl !== 5'b00011 || ctrl_state !== 2'd1) begin
            $display("FAIL mem_ack_flush: ctl=%b state=%0d, need ctl=00011 state=1", ctl, ctrl_state);
        end else passed++;
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== 5'b00000 || ctrl_state !== 2'd0) begin
            $display("FAIL mem_back_to_run: ctl=%b state=%0d, need ctl=00000 state=0", ctl, ctrl_state);
        end else passed++;
        tick();
    endtask

    task automatic test_timeout();
        idle();
        dmem_req_ex = 1;
        tick();
        for (int i = 0; i < TO; i++) begin
            #1;
            checks++;
            if (ctrl_state !== 2'd1 || mem_err !== 1'b0) begin
                $display("FAIL timeout_wait[%0d]: state=%0d err=%b, need state=1 err=0",
                         i, ctrl_state, mem_err);
            end else passed++;
            tick();
        end
        #1;
        checks++;
        if (ctrl_state !== 2'd2 || mem_err !== 1'b1 || ctl !== 5'b11100) begin
            $display("FAIL timeout_err: state=%0d err=%b ctl=%b, need state=2 err=1 ctl=11100",
                     ctrl_state, mem_err, ctl);
        end else passed++;
        dmem_req_ex = 0; dmem_ack = 1;
        tick();
        tick();
        checks++;
        if (ctrl_state !== 2'd2 || mem_err !== 1'b1 || ctl !== 5'b11100) begin
            $display("FAIL err_sticky: state=%0d err=%b ctl=%b, need state=2 err=1 ctl=11100",
                     ctrl_state, mem_err, ctl);
        end else passed++;
        rst = 1;
        #1;
        checks++;
        if (ctrl_state !== 2'd0 || mem_err !== 1'b0 || ctl !== 5'b00000) begin
            $display("FAIL err_reset: state=%0d err=%b ctl=%b, need state=0 err=0 ctl=00000",
                     ctrl_state, mem_err, ctl);
        end else passed++;
        tick();
        rst = 0;
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        dmem_req_ex = 1;
        tick();
        tick();
        checks++;
        if (ctrl_state !== 2'd1 || ctl !== 5'b11100) begin
            $display("FAIL async_pre: state=%0d ctl=%b, need state=1 ctl=11100", ctrl_state, ctl);
        end else passed++;
        #2;
        rst = 1;
        #1;
        checks++;
        if (ctrl_state !== 2'd0 || ctl !== 5'b00000) begin
            $display("FAIL async_reset: state=%0d ctl=%b, need state=0 ctl=00000", ctrl_state, ctl);
        end else passed++;
        tick();
        rst = 0;
        idle();
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall, exp_flush;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle();
            is_load_ex = 1; reg_write_ex = 1; rd_ex = 5'(i + 1); rs1_id = 5'(i + 1); uses_rs1_id = 1;
            tick();
            idle();
            tick();
        end
        branch_taken_ex = 1;
        tick();
        idle();
        tick();
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 32'd2; exp_flush = 32'd1;
`else
        exp_stall = 32'd0; exp_flush = 32'd0;
`endif
        checks++;
        if (perf_stall_cycles !== exp_stall || perf_flush_count !== exp_flush) begin
            $display("FAIL perf_counts: stall=%0d flush=%0d, need %0d/%0d",
                     perf_stall_cycles, perf_flush_count, exp_stall, exp_flush);
        end else passed++;
    endtask

    task automatic test_random();
        logic [4:0]  exp_ctl;
        logic [1:0]  exp_state;
        logic        exp_err;
        logic [31:0] exp_stall, exp_flush;
        int          bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst             = (c % 50 == 25);
            is_load_ex      = 1'($urandom_range(0, 1));
            reg_write_ex    = ($urandom_range(0, 3) != 0);
            rd_ex           = 5'($urandom_range(0, 3));
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            uses_rs1_id     = 1'($urandom_range(0, 1));
            uses_rs2_id     = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            dmem_req_ex     = ($urandom_range(0, 3) == 0);
            dmem_ack        = ($urandom_range(0, 2) == 0);
            #1;
            exp_ctl   = model_ctl();
            exp_state = rst ? 2'd0 : 2'(m_mode);
            exp_err   = rst ? 1'b0 : m_err;
            checks++;
            if (ctl !== exp_ctl || ctrl_state !== exp_state || mem_err !== exp_err) begin
                if (bad < 10)
                    $display("FAIL random[%0d]: ctl=%b state=%0d err=%b, need ctl=%b state=%0d err=%b",
                             c, ctl, ctrl_state, mem_err, exp_ctl, exp_state, exp_err);
                bad++;
            end else passed++;
            model_advance(exp_ctl);
            tick();
        end
        rst = 0;
        idle();
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = m_stalls; exp_flush = m_flushes;
`else
        exp_stall = 32'd0; exp_flush = 32'd0;
`endif
        #1;
        checks++;
        if (perf_stall_cycles !== exp_stall || perf_flush_count !== exp_flush) begin
            $display("FAIL random_perf: stall=%0d flush=%0d, need %0d/%0d",
                     perf_stall_cycles, perf_flush_count, exp_stall, exp_flush);
        end else passed++;
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        test_reset();
        test_load_use();
        test_branch_over_lu();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
